// File: rtl/vc_fifo.sv
// -----------------------------------------------------------------------------
// vc_fifo -- multi-channel first-word-fall-through FIFO
//
// Each virtual channel owns an independent circular buffer of DEPTH words with
// its own read pointer, write pointer and occupancy count. The head entry of
// the channel selected by pop_vc is presented combinationally on data_out, so
// a word pushed in one cycle can be read in the next.
//
// Parameters
//   WIDTH     data word width in bits
//   DEPTH     entries per channel (2..64)
//   NUM_VC    number of virtual channels (1..8)
//   AF_LEVEL  almost_full asserts when free entries <= AF_LEVEL (1..DEPTH-1)
//
// Ports
//   clk          single clock, all state updates on the rising edge
//   rst          synchronous active-high reset (pointers, counts, err)
//   push_req     write request
//   push_vc      target channel of the write
//   data_in      write data
//   pop_req      read request
//   pop_vc       channel to read; also selects data_out
//   data_out     head entry of channel pop_vc (don't-care when empty)
//   full         per-channel full flag
//   empty        per-channel empty flag
//   almost_full  per-channel almost-full flag
//   err          sticky protocol-error flag
//
// Build option
//   VC_FIFO_ERR_EN  when defined, err is set one cycle after any rejected
//                   request and holds until reset; when undefined err is 0.
// -----------------------------------------------------------------------------
module vc_fifo #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 4,
    parameter int NUM_VC   = 2,
    parameter int AF_LEVEL = 1,
    localparam int VCW     = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_req,
    input  logic [VCW-1:0]    push_vc,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              pop_req,
    input  logic [VCW-1:0]    pop_vc,
    output logic [WIDTH-1:0]  data_out,
    output logic [NUM_VC-1:0] full,
    output logic [NUM_VC-1:0] empty,
    output logic [NUM_VC-1:0] almost_full,
    output logic              err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [PW-1:0]  PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0]  CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0]  CNT_AF   = CW'(AF_LEVEL);
    // One extra bit so the range check is never trivially constant.
    localparam logic [VCW:0]   VC_LIMIT = (VCW + 1)'(NUM_VC);

    // Circular pointer increment with explicit wrap from DEPTH-1 to 0, so
    // non-power-of-two depths behave correctly.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] n;
        if (p == PTR_LAST) begin
            n = '0;
        end else begin
            n = p + PW'(1);
        end
        return n;
    endfunction

    logic [WIDTH-1:0] mem_r    [NUM_VC][DEPTH];
    logic [PW-1:0]    rd_ptr_r [NUM_VC];
    logic [PW-1:0]    wr_ptr_r [NUM_VC];
    logic [CW-1:0]    count_r  [NUM_VC];

    logic              push_vc_ok_s;
    logic              pop_vc_ok_s;
    logic [NUM_VC-1:0] push_hit_s;
    logic [NUM_VC-1:0] pop_hit_s;
    logic [NUM_VC-1:0] push_acc_s;
    logic [NUM_VC-1:0] pop_acc_s;
    logic [NUM_VC-1:0] full_s;
    logic [NUM_VC-1:0] empty_s;
    logic [NUM_VC-1:0] af_s;
    logic [VCW-1:0]    pop_idx_s;

    // Status flags decoded purely from the registered occupancy counts.
    always_comb begin
        full_s  = '0;
        empty_s = '0;
        af_s    = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            full_s[v]  = (count_r[v] == CNT_FULL);
            empty_s[v] = (count_r[v] == {CW{1'b0}});
            af_s[v]    = ((CNT_FULL - count_r[v]) <= CNT_AF);
        end
    end

    assign full        = full_s;
    assign empty       = empty_s;
    assign almost_full = af_s;

    // Request decode: a request is accepted only for an in-range channel whose
    // registered flags allow it; a same-cycle pop never frees room for a push.
    always_comb begin
        push_vc_ok_s = ({1'b0, push_vc} < VC_LIMIT);
        pop_vc_ok_s  = ({1'b0, pop_vc} < VC_LIMIT);
        push_hit_s   = '0;
        pop_hit_s    = '0;
        push_acc_s   = '0;
        pop_acc_s    = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            push_hit_s[v] = push_req && push_vc_ok_s && (push_vc == VCW'(v));
            pop_hit_s[v]  = pop_req && pop_vc_ok_s && (pop_vc == VCW'(v));
            push_acc_s[v] = push_hit_s[v] && !full_s[v];
            pop_acc_s[v]  = pop_hit_s[v] && !empty_s[v];
        end
    end

    // Pointer and count registers for every channel; reset overrides requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < NUM_VC; v++) begin
                rd_ptr_r[v] <= '0;
                wr_ptr_r[v] <= '0;
                count_r[v]  <= '0;
            end
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (push_acc_s[v]) begin
                    wr_ptr_r[v] <= ptr_inc(wr_ptr_r[v]);
                end else begin
                    wr_ptr_r[v] <= wr_ptr_r[v];
                end
                if (pop_acc_s[v]) begin
                    rd_ptr_r[v] <= ptr_inc(rd_ptr_r[v]);
                end else begin
                    rd_ptr_r[v] <= rd_ptr_r[v];
                end
                case ({push_acc_s[v], pop_acc_s[v]})
                    2'b10:   count_r[v] <= count_r[v] + CW'(1);
                    2'b01:   count_r[v] <= count_r[v] - CW'(1);
                    default: count_r[v] <= count_r[v];
                endcase
            end
        end
    end

    // Storage write port; contents are deliberately not cleared by reset, but
    // a push coinciding with reset is discarded.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (push_acc_s[v]) begin
                    mem_r[v][wr_ptr_r[v]] <= data_in;
                end
            end
        end
    end

    // First-word-fall-through read path; an out-of-range pop_vc is steered to
    // channel 0 so the array is never indexed past its end.
    always_comb begin
        if (pop_vc_ok_s) begin
            pop_idx_s = pop_vc;
        end else begin
            pop_idx_s = '0;
        end
        data_out = mem_r[pop_idx_s][rd_ptr_r[pop_idx_s]];
    end

`ifdef VC_FIFO_ERR_EN
    logic err_r;
    logic rej_s;

    // Any request that was not accepted (full, empty or bad channel) is an error.
    always_comb begin
        rej_s = (push_req && !(|push_acc_s)) || (pop_req && !(|pop_acc_s));
    end

    // Sticky error register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (rej_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/vc_fifo.md
VC_FIFO -- requirements
Module: vc_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, entries per virtual channel, legal range 2..64.
REQ-003 SHALL have parameter NUM_VC, default 2, number of virtual channels, legal range 1..8; VCW = max(1, clog2(NUM_VC)).
REQ-004 SHALL have parameter AF_LEVEL, default 1, free-entry threshold for almost_full, legal range 1..DEPTH-1.
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port push_req, input, 1, active-high write request.
REQ-008 SHALL have port push_vc, input, VCW, target channel of the write.
REQ-009 SHALL have port data_in, input, WIDTH, write data.
REQ-010 SHALL have port pop_req, input, 1, active-high read request.
REQ-011 SHALL have port pop_vc, input, VCW, channel to read.
REQ-012 SHALL have port data_out, output, WIDTH, head entry of channel pop_vc.
REQ-013 SHALL have port full, output, NUM_VC, per-channel full flag.
REQ-014 SHALL have port empty, output, NUM_VC, per-channel empty flag.
REQ-015 SHALL have port almost_full, output, NUM_VC, per-channel flag, set when free entries <= AF_LEVEL.
REQ-016 SHALL have port err, output, 1, sticky protocol-error flag.

Function
REQ-017 SHALL hold one independent circular buffer per channel, each with a read pointer, a write pointer and a count register 0..DEPTH; pointers wrap from DEPTH-1 to 0.
REQ-018 SHALL provide first-word-fall-through: data_out is combinational from the stored head of pop_vc, with 0-cycle read latency; data_out is don't-care when empty[pop_vc]=1.
REQ-019 SHALL accept a push when push_req=1, push_vc<NUM_VC and full[push_vc]=0; the word is readable on data_out in the next cycle.
REQ-020 SHALL accept a pop when pop_req=1, pop_vc<NUM_VC and empty[pop_vc]=0; the head advances at the clock edge.
REQ-021 SHALL evaluate full and empty on registered state only: a push to a full channel is rejected even if the same channel is popped in the same cycle.
REQ-022 SHALL accept a simultaneous push and pop to the same non-full, non-empty channel, leaving its count unchanged.
REQ-023 SHALL reject a pop on an empty channel while still accepting a simultaneous push to that channel.
REQ-024 SHALL accept a simultaneous push and pop to different channels independently.
REQ-025 SHALL leave rejected requests without effect on any storage, pointer or count.
REQ-026 SHALL derive the flags from the count register: full = (count==DEPTH), empty = (count==0), almost_full = (DEPTH-count <= AF_LEVEL).

Reset
REQ-027 SHALL, when rst=1 at a clock edge, clear all pointers and counts and err; this overrides any push or pop in the same cycle.
REQ-028 SHALL drive full=0, empty=all ones and almost_full=0 after reset; storage contents are not reset.
REQ-029 SHALL discard all queued data when reset is asserted mid-operation; the first push after reset lands in entry 0.

Configuration
REQ-030 SHALL, when macro VC_FIFO_ERR_EN is defined, set err one cycle after any rejected request (push to a full channel, pop from an empty channel, or a channel index >= NUM_VC); err then holds until reset.
REQ-031 SHALL, when VC_FIFO_ERR_EN is undefined, tie err to 0 and omit the error logic; rejection behaviour is unchanged.

Verification
REQ-032 Defaults, reset, then push 0xA001..0xA004 to VC0 -> full=2'b01, almost_full[0] set after the 3rd push, data_out with pop_vc=0 reads 0xA001.
REQ-033 VC0 full; push 0xBEEF to VC0 and pop VC0 in the same cycle -> pop accepted, push dropped, count becomes 3, err=1 (with the macro) or 0 (without).
REQ-034 VC1 empty; push 0x1234 to VC1 and pop VC1 in the same cycle -> pop ignored, next cycle empty[1]=0 and data_out=0x1234.
REQ-035 Push 0x0001 to VC0 and pop VC1 holding 0x00FF in the same cycle -> both accepted, VC0 count 1, empty[1]=1.
REQ-036 Run 10 push/pop pairs through VC1 with DEPTH=4 -> pointers wrap, data is read in order, and no flag glitches occur.
REQ-037 Reset asserted while VC0 holds 3 entries and push_req=1 -> next cycle empty=2'b11 and err=0.
